// File: rtl/rsa_block_sequencer.sv
// Byte-stream sequencer for Rsa256Core: loads n, d, then each ciphertext block, runs the core
// and streams the plaintext out MSB first. Optional core watchdog: define RSA_SEQ_TIMEOUT_EN.
module rsa_block_sequencer #(
    parameter int unsigned KEY_BYTES      = 32,
    parameter int unsigned OUT_BYTES      = 31,
    parameter int unsigned TIMEOUT_CYCLES = 2**20
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [7:0]   i_rx_data,
    input  logic         i_rx_valid,
    output logic         o_rx_ready,
    output logic [7:0]   o_tx_data,
    output logic         o_tx_valid,
    input  logic         i_tx_ready,
    output logic         o_core_start,
    output logic [255:0] o_core_a,
    output logic [255:0] o_core_d,
    output logic [255:0] o_core_n,
    input  logic [255:0] i_core_dec,
    input  logic         i_core_finished,
    input  logic         i_key_reload,
    output logic         o_busy,
    output logic         o_timeout
);
    localparam int unsigned     CntW    = $clog2(KEY_BYTES);
    localparam int unsigned     OutW    = 8 * OUT_BYTES;
    localparam logic [CntW-1:0] KeyLast = CntW'(KEY_BYTES - 1);
    localparam logic [CntW-1:0] OutLast = CntW'(OUT_BYTES - 1);

    typedef enum logic [2:0] {StKeyN, StKeyD, StEnc, StStart, StWait, StSend} state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic              pend_q;
    logic [255:0]      n_q, d_q, a_q;
    logic [OutW-1:0]   out_sr_q;
    logic              rx_fire;

`ifdef RSA_SEQ_TIMEOUT_EN
    localparam logic [20:0] TmoLast = 21'(TIMEOUT_CYCLES - 1);
    logic [20:0] tmo_cnt_q;
    logic        timeout_q;
    assign o_timeout = timeout_q;
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign o_timeout  = 1'b0;
`endif

    logic unused_dec;
    assign unused_dec = ^i_core_dec[255:OutW];

    // Gated by reset so every output reads 0 while reset is held.
    assign o_rx_ready   = i_rst_n && (state_q == StKeyN || state_q == StKeyD || state_q == StEnc);
    assign rx_fire      = i_rx_valid && o_rx_ready;
    assign o_tx_valid   = (state_q == StSend);
    assign o_tx_data    = out_sr_q[OutW-1 -: 8];
    assign o_core_start = (state_q == StStart);
    assign o_busy       = (state_q == StStart || state_q == StWait || state_q == StSend);
    assign o_core_a     = a_q;
    assign o_core_d     = d_q;
    assign o_core_n     = n_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= StKeyN;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            n_q      <= '0;
            d_q      <= '0;
            a_q      <= '0;
            out_sr_q <= '0;
`ifdef RSA_SEQ_TIMEOUT_EN
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                StKeyN, StKeyD: begin
                    if (i_key_reload) begin
                        state_q <= StKeyN;
                        cnt_q   <= '0;
                        pend_q  <= 1'b0;
                        n_q     <= '0;
                        d_q     <= '0;
                    end else if (rx_fire) begin
                        if (state_q == StKeyN) n_q <= {n_q[247:0], i_rx_data};
                        else                   d_q <= {d_q[247:0], i_rx_data};
                        if (cnt_q == KeyLast) begin
                            cnt_q   <= '0;
                            state_q <= (state_q == StKeyN) ? StKeyD : StEnc;
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                end
                StEnc: begin
                    if (i_key_reload && cnt_q == '0) begin
                        state_q <= StKeyN;
                        pend_q  <= 1'b0;
                        n_q     <= '0;
                        d_q     <= '0;
                    end else begin
                        if (i_key_reload) pend_q <= 1'b1;
                        if (rx_fire) begin
                            a_q <= {a_q[247:0], i_rx_data};
                            if (cnt_q == KeyLast) begin
                                cnt_q   <= '0;
                                state_q <= StStart;
`ifdef RSA_SEQ_TIMEOUT_EN
                                tmo_cnt_q <= '0;
                                timeout_q <= 1'b0;
`endif
                            end else begin
                                cnt_q <= cnt_q + CntW'(1);
                            end
                        end
                    end
                end
                StStart: begin
                    if (i_key_reload) pend_q <= 1'b1;
                    state_q <= StWait;
                end
                StWait: begin
                    if (i_key_reload) pend_q <= 1'b1;
                    if (i_core_finished) begin
                        out_sr_q <= i_core_dec[OutW-1:0];
                        state_q  <= StSend;
                    end
`ifdef RSA_SEQ_TIMEOUT_EN
                    else if (tmo_cnt_q == TmoLast) begin
                        timeout_q <= 1'b1;
                        state_q   <= StEnc;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 21'd1;
                    end
`endif
                end
                StSend: begin
                    if (i_key_reload) pend_q <= 1'b1;
                    if (i_tx_ready) begin
                        out_sr_q <= out_sr_q << 8;
                        if (cnt_q == OutLast) begin
                            cnt_q <= '0;
                            // A reload arriving on the last byte is honoured immediately.
                            if (pend_q || i_key_reload) begin
                                state_q <= StKeyN;
                                pend_q  <= 1'b0;
                                n_q     <= '0;
                                d_q     <= '0;
                            end else begin
                                state_q <= StEnc;
                            end
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                end
                default: state_q <= StKeyN;
            endcase
        end
    end
endmodule

// File: tb/tb_rsa_block_sequencer.sv
// Self-checking bench for rsa_block_sequencer: random keys/blocks against a byte-level model.
module tb_rsa_block_sequencer;
    localparam int unsigned KB = 32;
    localparam int unsigned OB = 31;
`ifdef RSA_SEQ_TIMEOUT_EN
    localparam int unsigned TMO = 64;
`else
    localparam int unsigned TMO = 2**20;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   i_rx_data = '0;
    logic         i_rx_valid = 1'b0;
    logic         o_rx_ready;
    logic [7:0]   o_tx_data;
    logic         o_tx_valid;
    logic         i_tx_ready = 1'b0;
    logic         o_core_start;
    logic [255:0] o_core_a, o_core_d, o_core_n;
    logic [255:0] i_core_dec = '0;
    logic         i_core_finished = 1'b0;
    logic         i_key_reload = 1'b0;
    logic         o_busy;
    logic         o_timeout;

    int n_cmp = 0;
    int n_err = 0;
    logic [255:0] exp_n, exp_d;

    always #5 clk = ~clk;

    rsa_block_sequencer #(
        .KEY_BYTES(KB), .OUT_BYTES(OB), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready),
        .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
        .o_core_start(o_core_start), .o_core_a(o_core_a), .o_core_d(o_core_d),
        .o_core_n(o_core_n), .i_core_dec(i_core_dec), .i_core_finished(i_core_finished),
        .i_key_reload(i_key_reload), .o_busy(o_busy), .o_timeout(o_timeout)
    );

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom();
        return v;
    endfunction

    // Plaintext byte k (0 = first sent) is byte k of dec[247:0] counted from the top.
    function automatic logic [7:0] exp_byte(input logic [255:0] dec, input int k);
        logic [255:0] t;
        t = dec >> (8 * (OB - 1 - k));
        return t[7:0];
    endfunction

    // Sends bytes first..KB-1 of v, MSB first, with random idle gaps.
    task automatic send_operand(input logic [255:0] v, input int first);
        for (int i = first; i < KB; i++) begin
            int guard;
            if ($urandom_range(0, 3) == 0) begin
                i_rx_valid = 1'b0;
                @(negedge clk);
            end
            i_rx_valid = 1'b1;
            i_rx_data  = v[255 - 8*i -: 8];
            guard = 0;
            while (!o_rx_ready && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 50) begin
                n_cmp++; n_err++;
                $display("FAIL rx_ready_wait: got 0 need 1 (byte %0d)", i);
            end
            @(negedge clk);
        end
        i_rx_valid = 1'b0;
    endtask

    // One full ciphertext block: enc in, core model answers after delay, 31 bytes out.
    task automatic run_block(input logic [255:0] enc, input logic [255:0] dec, input int delay,
                             input bit reload_in_wait, input int stall_at, input int abort_at);
        int  idx, guard, stall;
        bit  bad, rdy;
        send_operand(enc, 0);
        n_cmp++;
        if (o_core_start !== 1'b1 || o_busy !== 1'b1) begin
            n_err++;
            $display("FAIL start_pulse: got start=%0b busy=%0b need 1/1", o_core_start, o_busy);
        end
        n_cmp++;
        if (o_core_a !== enc || o_core_n !== exp_n || o_core_d !== exp_d) begin
            n_err++;
            $display("FAIL operands: got a=%h need %h", o_core_a, enc);
        end
        n_cmp++;
        if (o_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_at_start: got %0b need 0", o_timeout);
        end
        @(negedge clk);
        n_cmp++;
        if (o_core_start !== 1'b0) begin
            n_err++;
            $display("FAIL start_width: got %0b need 0", o_core_start);
        end
        bad = 1'b0;
        for (int c = 0; c < delay; c++) begin
            i_key_reload = reload_in_wait && (c == delay / 2);
            if (o_core_start || o_tx_valid || !o_busy) bad = 1'b1;
            @(negedge clk);
        end
        i_key_reload = 1'b0;
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL wait_quiet: got activity during wait need none");
        end
        i_core_dec      = dec;
        i_core_finished = 1'b1;
        @(negedge clk);
        i_core_finished = 1'b0;
        i_core_dec      = rand256();
        n_cmp++;
        if (o_tx_valid !== 1'b1 || o_core_a !== enc || o_core_n !== exp_n) begin
            n_err++;
            $display("FAIL send_latency: got tx_valid=%0b need 1", o_tx_valid);
        end
        idx = 0; guard = 0; stall = 0;
        while (idx < OB && guard < 400) begin
            if (idx == abort_at) begin
                i_tx_ready = 1'b0;
                return;
            end
            if (idx == stall_at && stall < 5) begin
                rdy = 1'b0;
                stall++;
            end else begin
                rdy = ($urandom_range(0, 3) != 0);
            end
            i_tx_ready = rdy;
            n_cmp++;
            if (o_tx_valid !== 1'b1 || o_tx_data !== exp_byte(dec, idx)) begin
                n_err++;
                $display("FAIL tx_byte[%0d]: got valid=%0b data=%h need 1/%h",
                         idx, o_tx_valid, o_tx_data, exp_byte(dec, idx));
            end
            @(negedge clk);
            if (rdy) idx++;
            guard++;
        end
        i_tx_ready = 1'b0;
        if (guard >= 400) begin
            n_cmp++; n_err++;
            $display("FAIL tx_drain: got %0d bytes need %0d", idx, OB);
        end
        n_cmp++;
        if (o_tx_valid !== 1'b0 || o_busy !== 1'b0 || o_rx_ready !== 1'b1) begin
            n_err++;
            $display("FAIL after_send: got valid=%0b busy=%0b ready=%0b need 0/0/1",
                     o_tx_valid, o_busy, o_rx_ready);
        end
        n_cmp++;
        if (o_core_n !== (reload_in_wait ? 256'd0 : exp_n)) begin
            n_err++;
            $display("FAIL key_after_block: got n=%h reload=%0b", o_core_n, reload_in_wait);
        end
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if (o_rx_ready !== 1'b0 || o_tx_valid !== 1'b0 || o_tx_data !== 8'h00 ||
            o_core_start !== 1'b0 || o_busy !== 1'b0 || o_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got rdy=%0b txv=%0b txd=%h st=%0b busy=%0b need all 0",
                     o_rx_ready, o_tx_valid, o_tx_data, o_core_start, o_busy);
        end
        n_cmp++;
        if (o_core_a !== '0 || o_core_d !== '0 || o_core_n !== '0) begin
            n_err++;
            $display("FAIL reset_operands: got nonzero need 0");
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (o_rx_ready !== 1'b1 || o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got rdy=%0b busy=%0b need 1/0", o_rx_ready, o_busy);
        end
    endtask

    task automatic test_key_restart();
        logic [255:0] v;
        logic [7:0]   b;
        v = rand256();
        send_operand(v, 0);
        for (int i = 0; i < 5; i++) begin
            i_rx_valid = 1'b1;
            i_rx_data  = v[8*i +: 8];
            @(negedge clk);
        end
        // Reload with a byte offered in the same cycle: byte must be dropped.
        i_key_reload = 1'b1;
        i_rx_data    = 8'h5A;
        @(negedge clk);
        i_key_reload = 1'b0;
        i_rx_valid   = 1'b0;
        n_cmp++;
        if (o_core_n !== '0 || o_core_d !== '0) begin
            n_err++;
            $display("FAIL restart_clear: got n=%h d=%h need 0", o_core_n, o_core_d);
        end
        b = 8'($urandom());
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        @(negedge clk);
        i_rx_valid = 1'b0;
        n_cmp++;
        if (o_core_n !== {248'd0, b} || o_core_d !== '0) begin
            n_err++;
            $display("FAIL restart_keyn: got n=%h need %h", o_core_n, {248'd0, b});
        end
        i_key_reload = 1'b1;
        @(negedge clk);
        i_key_reload = 1'b0;
    endtask

    task automatic test_first_block();
        exp_n = rand256();
        exp_n[255:224] = 32'hCA3586E7;
        exp_d = rand256();
        send_operand(exp_n, 0);
        send_operand(exp_d, 0);
        run_block(rand256(), rand256(), (TMO > 100) ? 100 : int'(TMO / 2), 1'b0, -1, -1);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 2; k++)
            run_block(rand256(), rand256(), int'($urandom_range(5, 40)), 1'b0, -1, -1);
    endtask

    task automatic test_tx_stall();
        run_block(rand256(), rand256(), 10, 1'b0, 12, -1);
    endtask

    task automatic test_finish_ignored();
        i_core_dec      = rand256();
        i_core_finished = 1'b1;
        @(negedge clk);
        i_core_finished = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (o_tx_valid !== 1'b0 || o_busy !== 1'b0 || o_rx_ready !== 1'b1) begin
            n_err++;
            $display("FAIL stray_finished: got txv=%0b busy=%0b need 0/0", o_tx_valid, o_busy);
        end
    endtask

    task automatic test_reload_in_wait();
        logic [255:0] nn;
        run_block(rand256(), rand256(), 20, 1'b1, -1, -1);
        nn = rand256();
        i_rx_valid = 1'b1;
        i_rx_data  = nn[255:248];
        @(negedge clk);
        i_rx_valid = 1'b0;
        n_cmp++;
        if (o_core_n !== {248'd0, nn[255:248]}) begin
            n_err++;
            $display("FAIL reload_new_n: got %h need %h", o_core_n, {248'd0, nn[255:248]});
        end
        send_operand(nn, 1);
        exp_n = nn;
        exp_d = rand256();
        send_operand(exp_d, 0);
        run_block(rand256(), rand256(), 15, 1'b0, -1, -1);
    endtask

`ifdef RSA_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int cyc;
        bit bad;
        send_operand(rand256(), 0);
        cyc = 0;
        bad = 1'b0;
        while (!o_timeout && cyc < 200) begin
            if (o_tx_valid) bad = 1'b1;
            @(negedge clk);
            cyc++;
        end
        // One START cycle plus TMO cycles in the wait state.
        n_cmp++;
        if (cyc !== int'(TMO) + 1 || bad) begin
            n_err++;
            $display("FAIL timeout_cycles: got %0d tx=%0b need %0d tx=0", cyc, bad, TMO + 1);
        end
        n_cmp++;
        if (o_rx_ready !== 1'b1 || o_busy !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_state: got rdy=%0b busy=%0b need 1/0", o_rx_ready, o_busy);
        end
        i_core_finished = 1'b1;
        @(negedge clk);
        i_core_finished = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (o_tx_valid !== 1'b0 || o_timeout !== 1'b1) begin
            n_err++;
            $display("FAIL late_finished: got txv=%0b tmo=%0b need 0/1", o_tx_valid, o_timeout);
        end
        run_block(rand256(), rand256(), 10, 1'b0, -1, -1);
    endtask
`endif

    task automatic test_reset_mid_send();
        run_block(rand256(), rand256(), 8, 1'b0, -1, 10);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (o_tx_valid !== 1'b0 || o_tx_data !== 8'h00 || o_busy !== 1'b0 ||
            o_rx_ready !== 1'b0 || o_core_start !== 1'b0 || o_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: got txv=%0b txd=%h busy=%0b rdy=%0b need all 0",
                     o_tx_valid, o_tx_data, o_busy, o_rx_ready);
        end
        n_cmp++;
        if (o_core_n !== '0 || o_core_d !== '0 || o_core_a !== '0) begin
            n_err++;
            $display("FAIL async_reset_key: got n=%h need 0", o_core_n);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (o_rx_ready !== 1'b1 || o_busy !== 1'b0 || o_tx_valid !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset: got rdy=%0b busy=%0b need 1/0", o_rx_ready, o_busy);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish need finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        test_reset();
        test_key_restart();
        test_first_block();
        test_back_to_back();
        test_tx_stall();
        test_finish_ignored();
        test_reload_in_wait();
`ifdef RSA_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_send();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
